// File: rtl/vga_frame_reader_if.sv
// vga_frame_reader_if: memory read-request bus and line-buffer push bus of the frame reader.
// Signals:
//   mem_req/mem_addr/mem_rdy      read request, accepted on mem_req & mem_rdy
//   mem_rvalid/mem_rdata          in-order read return
//   linebuffer_data/vld/rdy       {frame_start, rgb} push, transfer on vld & rdy
// Modports: master = frame reader side, slave = memory / line-buffer side.
`ifndef RGB_SIZE
`define RGB_SIZE 24
`endif
interface vga_frame_reader_if #(
    parameter int ADDR_W = 19
);
    logic                  mem_req;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_rdy;
    logic                  mem_rvalid;
    logic [`RGB_SIZE-1:0]  mem_rdata;
    logic [`RGB_SIZE:0]    linebuffer_data;
    logic                  linebuffer_vld;
    logic                  linebuffer_rdy;
    modport master (
        output mem_req, mem_addr, linebuffer_data, linebuffer_vld,
        input  mem_rdy, mem_rvalid, mem_rdata, linebuffer_rdy
    );
    modport slave (
        input  mem_req, mem_addr, linebuffer_data, linebuffer_vld,
        output mem_rdy, mem_rvalid, mem_rdata, linebuffer_rdy
    );
endinterface

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: framebuffer scan-out engine, reads H_DISP*V_DISP pixels per frame in raster
// order from pixel memory, buffers them in a prefetch FIFO and pushes {frame_start, rgb} words
// to the line buffer.
// Ports:
//   sys_clk     system clock
//   sys_rst     asynchronous active-low reset
//   enable      level, run continuous frame scan-out
//   busy        1 when not IDLE
//   frame_done  1-cycle pulse after the last pixel of a frame is accepted downstream
//   bus         vga_frame_reader_if.master (memory read bus + line-buffer push bus)
`ifndef RGB_SIZE
`define RGB_SIZE 24
`endif
module vga_frame_reader #(
    parameter int H_DISP         = 640,
    parameter int V_DISP         = 480,
    parameter int ADDR_W         = 19,
    parameter int BASE_ADDR      = 0,
    parameter int PREFETCH_DEPTH = 8
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               enable,
    output logic               busy,
    output logic               frame_done,
    vga_frame_reader_if.master bus
);
    localparam int N  = H_DISP * V_DISP;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    localparam int PW = $clog2(PREFETCH_DEPTH);
    localparam logic [CW-1:0]     LAST  = CW'(N - 1);
    localparam logic [PW:0]       DEPTH = (PW + 1)'(PREFETCH_DEPTH);
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]          state;
    logic [CW-1:0]       req_cnt;
    logic [CW-1:0]       ret_cnt;
    logic [CW-1:0]       out_cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [PW:0]         outstanding;
    logic [PW:0]         fifo_count;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [`RGB_SIZE:0]  fifo_mem [PREFETCH_DEPTH];
    logic                accept;
    logic                fifo_wr;
    logic                fifo_rd;

    // Reads in flight plus buffered words never exceed the FIFO size, so every return has a
    // slot and mem_rvalid needs no back-pressure. While a request waits for mem_rdy the sum
    // cannot grow, so a raised mem_req stays raised until accepted.
    assign bus.mem_req         = state == FETCH && outstanding + fifo_count < DEPTH;
    assign bus.mem_addr        = addr_q;
    assign bus.linebuffer_vld  = fifo_count != '0;
    assign bus.linebuffer_data = fifo_mem[rd_ptr];
    assign accept              = bus.mem_req && bus.mem_rdy;
    assign fifo_wr             = bus.mem_rvalid;
    assign fifo_rd             = bus.linebuffer_vld && bus.linebuffer_rdy;
    assign busy                = state != IDLE;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state       <= IDLE;
            req_cnt     <= '0;
            ret_cnt     <= '0;
            out_cnt     <= '0;
            addr_q      <= BASE;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            frame_done  <= 1'b0;
        end else begin
            // A frame only ends on acceptance of its last request; dropping enable earlier
            // lets the frame finish, keeping it high chains the next frame with no bubble.
            state <= state == IDLE  ? (enable ? FETCH : IDLE)
                   : state == FETCH ? (accept && req_cnt == LAST && !enable ? DRAIN : FETCH)
                   : (outstanding == '0 && fifo_count == '0 && !fifo_rd ? IDLE : DRAIN);
            if (accept) begin
                req_cnt <= req_cnt == LAST ? '0 : req_cnt + 1'b1;
                addr_q  <= req_cnt == LAST ? BASE : addr_q + 1'b1;
            end
            if (fifo_wr) begin
                ret_cnt <= ret_cnt == LAST ? '0 : ret_cnt + 1'b1;
                wr_ptr  <= wr_ptr + 1'b1;
            end
            if (fifo_rd) begin
                out_cnt <= out_cnt == LAST ? '0 : out_cnt + 1'b1;
                rd_ptr  <= rd_ptr + 1'b1;
            end
            outstanding <= outstanding + (PW + 1)'(accept) - (PW + 1)'(fifo_wr);
            fifo_count  <= fifo_count + (PW + 1)'(fifo_wr) - (PW + 1)'(fifo_rd);
            frame_done  <= fifo_rd && out_cnt == LAST;
        end
    end

    // Storage needs no reset: emptiness is defined by the pointers and count alone.
    always_ff @(posedge sys_clk) begin
        if (fifo_wr) fifo_mem[wr_ptr] <= {ret_cnt == '0, bus.mem_rdata};
    end
endmodule

// File: tb/tb_vga_frame_reader.sv
// tb_vga_frame_reader: randomized scenario bench for vga_frame_reader with a memory model
// and a raster-order reference of the expected pixel stream.
`ifndef RGB_SIZE
`define RGB_SIZE 24
`endif
module tb_vga_frame_reader;
    localparam int H     = 4;
    localparam int V     = 2;
    localparam int N     = H * V;
    localparam int AW    = 8;
    localparam int BASE  = 0;
    localparam int DEPTH = 8;
    localparam int DW    = `RGB_SIZE + 1;

    typedef struct {
        int addr;
        int due;
    } rd_t;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic enable  = 1'b0;
    logic busy;
    logic frame_done;

    vga_frame_reader_if #(.ADDR_W(AW)) bus ();

    vga_frame_reader #(
        .H_DISP(H), .V_DISP(V), .ADDR_W(AW), .BASE_ADDR(BASE), .PREFETCH_DEPTH(DEPTH)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable),
        .busy(busy), .frame_done(frame_done), .bus(bus)
    );

    always #5 sys_clk = ~sys_clk;

    int checks;
    int errors;
    int cyc;
    logic [`RGB_SIZE-1:0] mem_img [256];
    rd_t pend[$];
    int lat_min, lat_max, rdy_pct, lb_pct;
    int q_addr[$];
    int q_acc_cyc[$];
    logic [DW-1:0] q_out[$];
    int q_xfer_cyc[$];
    int q_done[$];
    int n_ret, n_xfer, credit_err, stab_err, max_sum;
    logic prev_req_stall, prev_lb_stall;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data;
    int inflight;

    // Memory-side legality: a return must always have a request outstanding.
    always @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) inflight <= 0;
        else begin
            assert (!(bus.mem_rvalid && inflight == 0)) else $error("mem_rvalid with no read outstanding");
            inflight <= inflight + ((bus.mem_req && bus.mem_rdy) ? 1 : 0) - (bus.mem_rvalid ? 1 : 0);
        end
    end

    // Raster-order reference: word k of the stream is pixel k mod N of the frame.
    function automatic logic [DW-1:0] exp_word(input int k);
        int p;
        p = k % N;
        return {p == 0, mem_img[BASE + p]};
    endfunction

    task automatic clear_logs();
        q_addr.delete(); q_acc_cyc.delete(); q_out.delete(); q_xfer_cyc.delete(); q_done.delete();
        credit_err = 0; stab_err = 0; max_sum = 0;
    endtask

    // One clock cycle, entered and left at the falling edge: drive the memory and line-buffer
    // inputs for this cycle, then log what the coming rising edge will transfer.
    task automatic step();
        int sum;
        if (frame_done) q_done.push_back(cyc);
        if (!sys_rst) begin
            pend.delete(); n_ret = 0; n_xfer = 0;
            prev_req_stall = 1'b0; prev_lb_stall = 1'b0;
            bus.mem_rvalid = 1'b0; bus.mem_rdy = 1'b0; bus.linebuffer_rdy = 1'b0;
        end else begin
            if (prev_req_stall && (!bus.mem_req || bus.mem_addr !== prev_addr)) stab_err++;
            if (prev_lb_stall && (!bus.linebuffer_vld || bus.linebuffer_data !== prev_data)) stab_err++;
            sum = pend.size() + n_ret - n_xfer;
            if (sum > max_sum) max_sum = sum;
            if (bus.mem_req && sum >= DEPTH) credit_err++;
            bus.mem_rdy        = $urandom_range(99) < rdy_pct;
            bus.linebuffer_rdy = $urandom_range(99) < lb_pct;
            bus.mem_rvalid     = 1'b0;
            bus.mem_rdata      = `RGB_SIZE'($urandom);
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = mem_img[pend[0].addr];
                pend.delete(0);
                n_ret++;
            end
            if (bus.mem_req && bus.mem_rdy) begin
                q_addr.push_back(int'(bus.mem_addr));
                q_acc_cyc.push_back(cyc);
                pend.push_back('{addr: int'(bus.mem_addr), due: cyc + int'($urandom_range(lat_max, lat_min))});
            end
            if (bus.linebuffer_vld && bus.linebuffer_rdy) begin
                q_out.push_back(bus.linebuffer_data);
                q_xfer_cyc.push_back(cyc);
                n_xfer++;
            end
            prev_req_stall = bus.mem_req && !bus.mem_rdy;
            prev_addr      = bus.mem_addr;
            prev_lb_stall  = bus.linebuffer_vld && !bus.linebuffer_rdy;
            prev_data      = bus.linebuffer_data;
        end
        @(negedge sys_clk);
        cyc++;
    endtask

    task automatic run_until_idle(input int budget);
        for (int i = 0; i < budget && (busy || i < 2); i++) step();
    endtask

    task automatic test_reset();
        lat_min = 1; lat_max = 1; rdy_pct = 100; lb_pct = 100;
        sys_rst = 1'b0; enable = 1'b0;
        repeat (3) step();
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req); end
        checks++; if (bus.linebuffer_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", bus.linebuffer_vld); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        checks++; if (bus.mem_addr !== AW'(BASE)) begin errors++; $display("FAIL reset_mem_addr: got %0d expected %0d", bus.mem_addr, BASE); end
        sys_rst = 1'b1;
        clear_logs();
        repeat (20) step();
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL idle_mem_req: got %b expected 0", bus.mem_req); end
        checks++; if (bus.linebuffer_vld !== 1'b0) begin errors++; $display("FAIL idle_vld: got %b expected 0", bus.linebuffer_vld); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
        checks++; if (q_addr.size() != 0) begin errors++; $display("FAIL idle_requests: got %0d expected 0", q_addr.size()); end
    endtask

    task automatic test_single_frame();
        int en_cyc;
        lat_min = 1; lat_max = 1; rdy_pct = 100; lb_pct = 100;
        clear_logs();
        en_cyc = cyc;
        enable = 1'b1;
        step();
        enable = 1'b0;
        run_until_idle(100);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got busy=%b expected 0", busy); end
        checks++; if (q_addr.size() != N) begin errors++; $display("FAIL single_req_count: got %0d expected %0d", q_addr.size(), N); end
        for (int i = 0; i < q_addr.size(); i++) begin
            checks++; if (q_addr[i] != BASE + i % N) begin errors++; $display("FAIL single_addr[%0d]: got %0d expected %0d", i, q_addr[i], BASE + i % N); end
        end
        if (q_acc_cyc.size() > 0) begin
            checks++; if (q_acc_cyc[0] != en_cyc + 1) begin errors++; $display("FAIL single_first_req_cycle: got %0d expected %0d", q_acc_cyc[0], en_cyc + 1); end
        end
        checks++; if (q_out.size() != N) begin errors++; $display("FAIL single_word_count: got %0d expected %0d", q_out.size(), N); end
        for (int i = 0; i < q_out.size(); i++) begin
            checks++; if (q_out[i] !== exp_word(i)) begin errors++; $display("FAIL single_word[%0d]: got %h expected %h", i, q_out[i], exp_word(i)); end
        end
        checks++; if (q_done.size() != 1) begin errors++; $display("FAIL single_done_count: got %0d expected 1", q_done.size()); end
        if (q_done.size() > 0 && q_xfer_cyc.size() >= N) begin
            checks++; if (q_done[0] != q_xfer_cyc[N-1] + 1) begin errors++; $display("FAIL single_done_cycle: got %0d expected %0d", q_done[0], q_xfer_cyc[N-1] + 1); end
        end
    endtask

    task automatic test_backpressure();
        lat_min = 1; lat_max = 1; rdy_pct = 100; lb_pct = 0;
        clear_logs();
        enable = 1'b1;
        step();
        enable = 1'b0;
        repeat (50) step();
        checks++; if (q_addr.size() != DEPTH) begin errors++; $display("FAIL bp_req_count: got %0d expected %0d", q_addr.size(), DEPTH); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL bp_mem_req: got %b expected 0", bus.mem_req); end
        checks++; if (bus.linebuffer_vld !== 1'b1) begin errors++; $display("FAIL bp_vld: got %b expected 1", bus.linebuffer_vld); end
        checks++; if (bus.linebuffer_data !== exp_word(0)) begin errors++; $display("FAIL bp_head: got %h expected %h", bus.linebuffer_data, exp_word(0)); end
        checks++; if (q_out.size() != 0) begin errors++; $display("FAIL bp_no_transfer: got %0d expected 0", q_out.size()); end
        lb_pct = 100;
        run_until_idle(100);
        checks++; if (q_out.size() != N) begin errors++; $display("FAIL bp_word_count: got %0d expected %0d", q_out.size(), N); end
        for (int i = 0; i < q_out.size(); i++) begin
            checks++; if (q_out[i] !== exp_word(i)) begin errors++; $display("FAIL bp_word[%0d]: got %h expected %h", i, q_out[i], exp_word(i)); end
        end
        checks++; if (stab_err != 0) begin errors++; $display("FAIL bp_stability: got %0d unstable cycles expected 0", stab_err); end
        checks++; if (credit_err != 0 || max_sum > DEPTH) begin errors++; $display("FAIL bp_credit: got %0d violations max %0d expected 0 max %0d", credit_err, max_sum, DEPTH); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        int wraps;
        lat_min = 1; lat_max = 1; rdy_pct = 100; lb_pct = 100;
        clear_logs();
        enable = 1'b1;
        for (int i = 0; i < 300 && q_out.size() < 3 * N; i++) step();
        enable = 1'b0;
        run_until_idle(200);
        checks++; if (q_out.size() < 3 * N || q_out.size() % N != 0) begin errors++; $display("FAIL b2b_word_count: got %0d expected a multiple of %0d >= %0d", q_out.size(), N, 3 * N); end
        wraps = 0;
        for (int i = 1; i < q_addr.size(); i++) begin
            if (q_addr[i] == BASE && q_addr[i-1] == BASE + N - 1) begin
                wraps++;
                checks++; if (q_acc_cyc[i] != q_acc_cyc[i-1] + 1) begin errors++; $display("FAIL b2b_wrap_bubble: got gap %0d expected 1", q_acc_cyc[i] - q_acc_cyc[i-1]); end
            end
        end
        checks++; if (wraps < 2) begin errors++; $display("FAIL b2b_wraps: got %0d expected >= 2", wraps); end
        for (int i = 0; i < q_out.size(); i++) begin
            checks++; if (q_out[i] !== exp_word(i)) begin errors++; $display("FAIL b2b_word[%0d]: got %h expected %h", i, q_out[i], exp_word(i)); end
        end
        checks++; if (q_done.size() != q_out.size() / N) begin errors++; $display("FAIL b2b_done_count: got %0d expected %0d", q_done.size(), q_out.size() / N); end
    endtask

    task automatic test_random(input int mem_rdy_pct, input int lb_rdy_pct);
        lat_min = 1; lat_max = 5; rdy_pct = mem_rdy_pct; lb_pct = lb_rdy_pct;
        clear_logs();
        enable = 1'b1;
        for (int i = 0; i < 3000 && q_out.size() < 3 * N; i++) step();
        enable = 1'b0;
        run_until_idle(1000);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_idle: got busy=%b expected 0", busy); end
        checks++; if (q_out.size() < 3 * N || q_out.size() % N != 0) begin errors++; $display("FAIL rand_word_count: got %0d expected a multiple of %0d >= %0d", q_out.size(), N, 3 * N); end
        checks++; if (q_addr.size() != q_out.size()) begin errors++; $display("FAIL rand_req_count: got %0d expected %0d", q_addr.size(), q_out.size()); end
        for (int i = 0; i < q_addr.size(); i++) begin
            checks++; if (q_addr[i] != BASE + i % N) begin errors++; $display("FAIL rand_addr[%0d]: got %0d expected %0d", i, q_addr[i], BASE + i % N); end
        end
        for (int i = 0; i < q_out.size(); i++) begin
            checks++; if (q_out[i] !== exp_word(i)) begin errors++; $display("FAIL rand_word[%0d]: got %h expected %h", i, q_out[i], exp_word(i)); end
        end
        checks++; if (q_done.size() != q_out.size() / N) begin errors++; $display("FAIL rand_done_count: got %0d expected %0d", q_done.size(), q_out.size() / N); end
        for (int j = 0; j < q_done.size() && j * N + N - 1 < q_xfer_cyc.size(); j++) begin
            checks++; if (q_done[j] != q_xfer_cyc[j*N+N-1] + 1) begin errors++; $display("FAIL rand_done_cycle[%0d]: got %0d expected %0d", j, q_done[j], q_xfer_cyc[j*N+N-1] + 1); end
        end
        checks++; if (credit_err != 0 || max_sum > DEPTH) begin errors++; $display("FAIL rand_credit: got %0d violations max %0d expected 0 max %0d", credit_err, max_sum, DEPTH); end
        checks++; if (stab_err != 0) begin errors++; $display("FAIL rand_stability: got %0d unstable cycles expected 0", stab_err); end
    endtask

    task automatic test_reset_mid_frame();
        lat_min = 2; lat_max = 2; rdy_pct = 100; lb_pct = 100;
        clear_logs();
        enable = 1'b1;
        for (int i = 0; i < 100 && q_out.size() < 5; i++) step();
        checks++; if (q_out.size() < 5) begin errors++; $display("FAIL midrst_reach_pixel5: got %0d words expected 5", q_out.size()); end
        sys_rst = 1'b0;
        #1;
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL midrst_mem_req: got %b expected 0", bus.mem_req); end
        checks++; if (bus.linebuffer_vld !== 1'b0) begin errors++; $display("FAIL midrst_vld: got %b expected 0", bus.linebuffer_vld); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (bus.mem_addr !== AW'(BASE)) begin errors++; $display("FAIL midrst_mem_addr: got %0d expected %0d", bus.mem_addr, BASE); end
        step();
        step();
        checks++; if (busy !== 1'b0 || bus.linebuffer_vld !== 1'b0) begin errors++; $display("FAIL midrst_held: got busy=%b vld=%b expected 0 0", busy, bus.linebuffer_vld); end
        clear_logs();
        sys_rst = 1'b1;
        for (int i = 0; i < 200 && q_out.size() < N; i++) step();
        enable = 1'b0;
        run_until_idle(200);
        checks++; if (q_out.size() < N || q_out.size() % N != 0) begin errors++; $display("FAIL midrst_word_count: got %0d expected a multiple of %0d", q_out.size(), N); end
        if (q_addr.size() > 0) begin
            checks++; if (q_addr[0] != BASE) begin errors++; $display("FAIL midrst_first_addr: got %0d expected %0d", q_addr[0], BASE); end
        end
        if (q_out.size() > 0) begin
            checks++; if (q_out[0][DW-1] !== 1'b1) begin errors++; $display("FAIL midrst_frame_start: got %b expected 1", q_out[0][DW-1]); end
        end
        for (int i = 0; i < q_out.size(); i++) begin
            checks++; if (q_out[i] !== exp_word(i)) begin errors++; $display("FAIL midrst_word[%0d]: got %h expected %h", i, q_out[i], exp_word(i)); end
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        n_ret = 0; n_xfer = 0;
        prev_req_stall = 1'b0; prev_lb_stall = 1'b0;
        bus.mem_rdy = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.linebuffer_rdy = 1'b0;
        for (int i = 0; i < 256; i++) mem_img[i] = `RGB_SIZE'($urandom);
        clear_logs();
        @(negedge sys_clk);
        test_reset();
        test_single_frame();
        test_backpressure();
        test_back_to_back();
        test_random(60, 50);
        test_random(30, 80);
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
